reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//   Parametrised multi-read-port register file for the pipelined MIPS datapath.
//   Adds a write-to-read bypass, a per-register pending scoreboard for hazard detection,
//   and a reset-driven clear sweep. Sits in ID: feeds operand muxes and the hazard unit.
//   Written from WB.
// PARAMETERS
//   DATA_W    32  register width in bits
//   NUM_REGS  32  number of architectural registers; power of 2, >= 2
//   ADDR_W    $clog2(NUM_REGS)  address width (derived; do not override)
//   NUM_RD    2   number of independent read ports, 1..4
//   BYPASS    1   1 = same-cycle write data forwarded to matching reads; 0 = no bypass
//   ZERO_REG  1   1 = register 0 reads 0, ignores writes/issues; 0 = ordinary register
// PORTS
//   clk         in   1               clock, rising edge
//   rst_n       in   1               asynchronous reset, active low
//   rd_addr     in   NUM_RD*ADDR_W   read addresses, port p at [p*ADDR_W +: ADDR_W]
//   rd_data     out  NUM_RD*DATA_W   read data, port p at [p*DATA_W +: DATA_W]
//   rd_busy     out  NUM_RD          1 = register on port p has an outstanding producer
//   wr_en       in   1               write strobe (WB)
//   wr_addr     in   ADDR_W          write address
//   wr_data     in   DATA_W          write data
//   issue_en    in   1               mark issue_addr pending (instruction leaving ID)
//   issue_addr  in   ADDR_W          destination register being issued
//   flush       in   1               clear every pending bit (branch/exception flush)
//   ready       out  1               1 = clear sweep finished, block accepts traffic
// BEHAVIOUR
//   - Reset (rst_n=0, async): FSM -> CLEAR, sweep counter = 0, all pending = 0, ready = 0.
//     Reset asserted mid-operation aborts everything and restarts the sweep.
//   - CLEAR: on each rising edge, writes 0 to entry[counter], then counter increments.
//     After NUM_REGS edges, FSM -> RUN; ready = 1 from that edge onward.
//     In CLEAR: wr_en, issue_en and flush are ignored; rd_data = 0; rd_busy = 0.
//   - RUN, write: on wr_en, entry[wr_addr] <= wr_data at the rising edge.
//     The value is visible to a combinational read in the next cycle.
//     With ZERO_REG=1, a write to addr 0 is dropped.
//   - Read (combinational) on each port p, in priority order:
//     1. ZERO_REG && addr==0 -> data 0, busy 0.
//     2. BYPASS && wr_en && wr_addr==addr -> data = wr_data, busy 0.
//     3. Otherwise -> data = entry[addr], busy = pending[addr].
//   - Scoreboard, per rising edge in RUN, in priority order:
//     1. flush -> all pending <= 0; a same-cycle issue_en is dropped.
//     2. wr_en clears pending[wr_addr].
//     3. issue_en sets pending[issue_addr]. If issue_en and wr_en target the same register,
//        issue wins and the bit ends at 1 (a newer producer exists).
//     4. issue to addr 0 with ZERO_REG=1 is dropped.
//   - Writing a register that is not pending is legal. Data is stored; pending stays 0.
//   - Read/write of the same address with BYPASS=0 returns the old value (read-before-write).
//   - All address inputs are full-range; no out-of-range case exists.
// STRUCTURE
//   - reg_file_pkg holds the FSM state enum (ST_CLEAR, ST_RUN) and the
//     rf_port_sel function (slice port p out of a packed bus).
//   - One sub-module, rf_read_port: per-port zero/bypass/busy mux, instantiated NUM_RD
//     times with generate. Storage, scoreboard and sweep FSM stay in reg_file_sb.
// TESTING
//   - Reset release: ready=0 for exactly 32 edges, then 1. Every rd_addr returns 0.
//     rd_busy=0 throughout. wr_en asserted during the sweep leaves no effect.
//   - Write/read: write r5=0xDEADBEEF, read port1 r5 next cycle -> 0xDEADBEEF.
//     Write r0=0x1234 -> reads r0=0 (ZERO_REG=1).
//   - Bypass: wr r7=0x55 while port0 reads r7 -> rd_data[0]=0x55 same cycle.
//     With BYPASS=0, the same stimulus returns the old r7.
//   - Scoreboard: issue r9 -> rd_busy=1 next cycle. Same-cycle issue r9 and wr r9 -> stays 1.
//     Subsequent wr r9 -> busy 0. flush with issue r3 -> no bits set.
//   - Reset mid-run: load r1..r4, pend r2, pulse rst_n low for a half cycle.
//     -> ready drops immediately, pending=0; after 32 edges all regs read 0.
//   - Config sweep: NUM_REGS=8, NUM_RD=4, DATA_W=16 -> 8-edge clear.
//     Four simultaneous distinct reads are correct.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the ID-stage register file with bypass and pending scoreboard.
package reg_file_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } rf_state_e;

  localparam int RF_BUS_W = 256;
  localparam int RF_SEL_W = 64;

  // Slice field p (each w bits wide) out of a packed multi-port bus.
  function automatic logic [RF_SEL_W-1:0] rf_port_sel(
    input logic [RF_BUS_W-1:0] bus,
    input int                  p,
    input int                  w
  );
    logic [RF_BUS_W-1:0] shifted;
    logic [RF_BUS_W-1:0] mask;
    shifted = bus >> (p * w);
    mask    = (RF_BUS_W'(1) << w) - RF_BUS_W'(1);
    return RF_SEL_W'(shifted & mask);
  endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: zero register, same-cycle write bypass, then stored data and pending bit.
module rf_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              run,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] entry_data,
  input  logic              entry_busy,
  output logic [DATA_W-1:0] data,
  output logic              busy
);

  logic zero_hit;
  logic byp_hit;

  assign zero_hit = (ZERO_REG != 0) && (addr == '0);
  assign byp_hit  = (BYPASS != 0) && wr_en && (wr_addr == addr);

  // While the clear sweep runs, storage is not yet valid, so everything reads as idle zero.
  always_comb begin
    data = '0;
    busy = 1'b0;
    if (run && !zero_hit) begin
      if (byp_hit) begin
        data = wr_data;
      end else begin
        data = entry_data;
        busy = entry_busy;
      end
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write bypass, per-register pending scoreboard and reset clear sweep.
//   state    | meaning
//   ST_CLEAR | sweeping zeros into every entry, traffic ignored, ready=0
//   ST_RUN   | normal operation, ready=1
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic                     ready
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

  rf_state_e           state_q;
  rf_state_e           state_d;
  logic [ADDR_W-1:0]   cnt_q;
  logic [ADDR_W-1:0]   cnt_d;
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;
  logic [DATA_W-1:0]   entry [NUM_REGS];
  logic                run;
  logic                wr_keep;
  logic                issue_keep;
  logic [RF_BUS_W-1:0] rd_addr_bus;

  assign run         = (state_q == ST_RUN);
  assign ready       = run;
  assign wr_keep     = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign issue_keep  = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
  assign rd_addr_bus = RF_BUS_W'(rd_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_CLEAR;
    endcase
  end

  // Storage has no reset of its own; the sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      entry[cnt_q] <= '0;
    end else if (wr_keep) begin
      entry[wr_addr] <= wr_data;
    end
  end

  // A same-edge issue to the register being written wins: a newer producer is in flight.
  always_comb begin
    pending_d = pending_q;
    if (!run || flush) begin
      pending_d = '0;
    end else begin
      if (wr_en) begin
        pending_d[wr_addr] = 1'b0;
      end
      if (issue_keep) begin
        pending_d[issue_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_p;

    assign addr_p = ADDR_W'(rf_port_sel(rd_addr_bus, p, ADDR_W));

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_port (
      .run        (run),
      .addr       (addr_p),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .entry_data (entry[addr_p]),
      .entry_busy (pending_q[addr_p]),
      .data       (rd_data[p*DATA_W +: DATA_W]),
      .busy       (rd_busy[p])
    );
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default config, a no-bypass twin, and a small 8x16 four-port build.
module tb_reg_file_sb;

  typedef struct {
    string       name;
    logic [63:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] obs_q[$];
  int          tests_run = 0;
  int          failed    = 0;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;
  logic        flush;
  logic        ready;
  logic [63:0] nb_rd_data;
  logic [1:0]  nb_rd_busy;
  logic        nb_ready;

  logic [11:0] s_rd_addr;
  logic [63:0] s_rd_data;
  logic [3:0]  s_rd_busy;
  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        s_issue_en;
  logic [2:0]  s_issue_addr;
  logic        s_flush;
  logic        s_ready;

  always #5 clk = ~clk;

  reg_file_sb u_dut (
    .clk (clk), .rst_n (rst_n), .rd_addr (rd_addr), .rd_data (rd_data), .rd_busy (rd_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .issue_en (issue_en),
    .issue_addr (issue_addr), .flush (flush), .ready (ready)
  );

  reg_file_sb #(.BYPASS(0)) u_nb (
    .clk (clk), .rst_n (rst_n), .rd_addr (rd_addr), .rd_data (nb_rd_data), .rd_busy (nb_rd_busy),
    .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data), .issue_en (issue_en),
    .issue_addr (issue_addr), .flush (flush), .ready (nb_ready)
  );

  reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(4)) u_small (
    .clk (clk), .rst_n (rst_n), .rd_addr (s_rd_addr), .rd_data (s_rd_data), .rd_busy (s_rd_busy),
    .wr_en (s_wr_en), .wr_addr (s_wr_addr), .wr_data (s_wr_data), .issue_en (s_issue_en),
    .issue_addr (s_issue_addr), .flush (s_flush), .ready (s_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string name, input logic [63:0] val, input logic [63:0] obs);
    exp_t e;
    e.name = name;
    e.val  = val;
    exp_q.push_back(e);
    obs_q.push_back(obs);
  endtask

  task automatic set_rd(input int p0, input int p1);
    rd_addr = {5'(p1), 5'(p0)};
  endtask

  task automatic write_reg(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 5'(a);
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic issue_reg(input int a);
    issue_en   = 1'b1;
    issue_addr = 5'(a);
    tick();
    issue_en   = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [63:0] o;
    int first_big = -1;
    int first_nb = -1;
    int first_small = -1;
    int clear_bad = 0;
    rst_n = 1'b0;
    rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    s_rd_addr = '0; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
    s_issue_en = 1'b0; s_issue_addr = '0; s_flush = 1'b0;
    repeat (3) @(negedge clk);
    expect_val("reset ready", 0, 64'(ready));
    expect_val("reset busy", 0, 64'(rd_busy));
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'hBAD0BAD0;
    issue_en = 1'b1; issue_addr = 5'd2;
    set_rd(2, 1);
    s_wr_en = 1'b1; s_wr_addr = 3'd1; s_wr_data = 16'hBADD;
    s_issue_en = 1'b1; s_issue_addr = 3'd2;
    s_rd_addr = {3'd1, 3'd2, 3'd1, 3'd2};
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (!ready && (rd_data != 0 || rd_busy != 0)) clear_bad++;
      if (!s_ready && (s_rd_data != 0 || s_rd_busy != 0)) clear_bad++;
      if (ready && first_big < 0) begin
        first_big = i;
        wr_en = 1'b0; issue_en = 1'b0;
      end
      if (nb_ready && first_nb < 0) first_nb = i;
      if (s_ready && first_small < 0) begin
        first_small = i;
        s_wr_en = 1'b0; s_issue_en = 1'b0;
      end
      if (first_big > 0 && first_small > 0 && first_nb > 0) break;
    end
    expect_val("sweep edges", 32, 64'(first_big));
    expect_val("sweep edges nb", 32, 64'(first_nb));
    expect_val("sweep edges small", 8, 64'(first_small));
    expect_val("clear outputs idle", 0, 64'(clear_bad));
    #1;
    expect_val("sweep wr ignored r1", 0, rd_data[63:32]);
    expect_val("sweep issue ignored r2", 0, 64'(rd_busy));
    expect_val("small sweep wr ignored", 0, s_rd_data);
    expect_val("small sweep issue ignored", 0, 64'(s_rd_busy));
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1;
      expect_val($sformatf("cleared r%0d", a), 0, rd_data);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e.val) begin
        failed++;
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    logic [63:0] o;
    write_reg(5, 32'hDEADBEEF);
    set_rd(0, 5);
    #2;
    expect_val("wr r5 read p1", 32'hDEADBEEF, rd_data[63:32]);
    expect_val("wr r5 busy", 0, 64'(rd_busy));
    expect_val("wr r5 read nb", 32'hDEADBEEF, nb_rd_data[63:32]);
    write_reg(0, 32'h1234);
    set_rd(0, 0);
    #2;
    expect_val("zero reg p0", 0, rd_data[31:0]);
    expect_val("zero reg p1", 0, rd_data[63:32]);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5678;
    #2;
    expect_val("zero reg no bypass", 0, rd_data[31:0]);
    tick();
    wr_en = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e.val) begin
        failed++;
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    logic [63:0] o;
    write_reg(7, 32'h11);
    set_rd(7, 5);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h55;
    #2;
    expect_val("bypass r7", 32'h55, rd_data[31:0]);
    expect_val("no-bypass old r7", 32'h11, nb_rd_data[31:0]);
    expect_val("bypass other port", 32'hDEADBEEF, rd_data[63:32]);
    tick();
    wr_en = 1'b0;
    #2;
    expect_val("after bypass r7", 32'h55, rd_data[31:0]);
    expect_val("after bypass r7 nb", 32'h55, nb_rd_data[31:0]);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e.val) begin
        failed++;
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_scoreboard();
    exp_t e;
    logic [63:0] o;
    issue_reg(9);
    set_rd(9, 3);
    #2;
    expect_val("issue r9 busy", 1, 64'(rd_busy[0]));
    expect_val("issue r9 busy nb", 1, 64'(nb_rd_busy[0]));
    issue_en = 1'b1; issue_addr = 5'd9;
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    #2;
    expect_val("bypass hides busy", 0, 64'(rd_busy[0]));
    expect_val("bypass data r9", 32'h99, rd_data[31:0]);
    expect_val("nb busy during wr", 1, 64'(nb_rd_busy[0]));
    tick();
    issue_en = 1'b0; wr_en = 1'b0;
    #2;
    expect_val("issue beats write", 1, 64'(rd_busy[0]));
    expect_val("r9 data stored", 32'h99, rd_data[31:0]);
    write_reg(9, 32'h77);
    #2;
    expect_val("wr clears r9", 0, 64'(rd_busy[0]));
    expect_val("r9 new data", 32'h77, rd_data[31:0]);
    write_reg(10, 32'hA);
    set_rd(10, 3);
    #2;
    expect_val("wr non-pending busy", 0, 64'(rd_busy[0]));
    expect_val("wr non-pending data", 32'hA, rd_data[31:0]);
    issue_reg(3);
    issue_reg(4);
    set_rd(3, 4);
    #2;
    expect_val("pend r3 r4", 2'b11, 64'(rd_busy));
    flush = 1'b1; issue_en = 1'b1; issue_addr = 5'd3;
    tick();
    flush = 1'b0; issue_en = 1'b0;
    #2;
    expect_val("flush drops issue", 0, 64'(rd_busy));
    issue_reg(0);
    set_rd(0, 3);
    #2;
    expect_val("issue r0 dropped", 0, 64'(rd_busy));
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e.val) begin
        failed++;
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    logic [63:0] o;
    int first = -1;
    for (int r = 1; r <= 4; r++) write_reg(r, 32'h100 + 32'(r));
    issue_reg(2);
    set_rd(2, 1);
    #2;
    expect_val("pre-reset busy r2", 1, 64'(rd_busy[0]));
    expect_val("pre-reset r1", 32'h101, rd_data[63:32]);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    expect_val("mid reset ready", 0, 64'(ready));
    expect_val("mid reset busy", 0, 64'(rd_busy));
    expect_val("mid reset small ready", 0, 64'(s_ready));
    #2;
    rst_n = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready) begin
        first = i;
        break;
      end
    end
    expect_val("mid reset sweep edges", 32, 64'(first));
    for (int a = 0; a < 32; a++) begin
      set_rd(a, 31 - a);
      #1;
      expect_val($sformatf("post reset r%0d", a), 0, rd_data);
      expect_val($sformatf("post reset busy r%0d", a), 0, 64'(rd_busy));
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e.val) begin
        failed++;
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.val);
      end
    end
  endtask

  task automatic test_small_config();
    exp_t e;
    logic [63:0] o;
    expect_val("small ready", 1, 64'(s_ready));
    for (int r = 0; r < 8; r++) begin
      s_wr_en = 1'b1; s_wr_addr = 3'(r); s_wr_data = 16'hA000 + 16'(r * 17);
      tick();
    end
    s_wr_en = 1'b0;
    s_rd_addr = {3'd7, 3'd1, 3'd6, 3'd3};
    #2;
    expect_val("small p0 r3", 16'hA033, s_rd_data[15:0]);
    expect_val("small p1 r6", 16'hA066, s_rd_data[31:16]);
    expect_val("small p2 r1", 16'hA011, s_rd_data[47:32]);
    expect_val("small p3 r7", 16'hA077, s_rd_data[63:48]);
    s_rd_addr = {3'd0, 3'd5, 3'd2, 3'd4};
    #2;
    expect_val("small four ports", {16'h0, 16'hA055, 16'hA022, 16'hA044}, s_rd_data);
    s_issue_en = 1'b1; s_issue_addr = 3'd5;
    tick();
    s_issue_en = 1'b0;
    s_wr_en = 1'b1; s_wr_addr = 3'd2; s_wr_data = 16'hBEEF;
    #2;
    expect_val("small busy r5", 4'b0100, 64'(s_rd_busy));
    expect_val("small bypass r2", 16'hBEEF, s_rd_data[31:16]);
    tick();
    s_wr_en = 1'b0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      tests_run++;
      if (o !== e.val) begin
        failed++;
        $display("FAIL %s: got %0h, expected %0h", e.name, o, e.val);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_reset_mid();
    test_small_config();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
